sym_vn_rank_lut: RTL and testbench

SYM_VN_RANK_LUT -- requirements
Module: sym_vn_rank_lut

---
 rtl/sym_vn_rank_lut.sv | 84 ++++++++
 tb/tb_sym_vn_rank_lut.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sym_vn_rank_lut.sv
// Dual-replica 32x3 rank LUT: each read port composes its address from two message fields.
// Define SYM_VN_RANK_RD_REG_EN to register the read data (one cycle of latency).
module sym_vn_rank_lut #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 5
) (
  input  logic              write_clk,
  input  logic              rst,
  input  logic [ADDR_W-4:0] y0_in_A,
  input  logic [2:0]        y1_in_A,
  input  logic [ADDR_W-4:0] y0_in_B,
  input  logic [2:0]        y1_in_B,
  output logic [ADDR_W-1:0] page_addr_A,
  output logic [ADDR_W-1:0] page_addr_B,
  output logic [DATA_W-1:0] lut_data0,
  output logic [DATA_W-1:0] lut_data1,
  input  logic [DATA_W-1:0] lut_in_bank0_replicate_0,
  input  logic [ADDR_W-1:0] page_write_addr_replicate_0,
  input  logic [DATA_W-1:0] lut_in_bank0_replicate_1,
  input  logic [ADDR_W-1:0] page_write_addr_replicate_1,
  input  logic              we
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] replica0_q [DEPTH];
  logic [DATA_W-1:0] replica0_d [DEPTH];
  logic [DATA_W-1:0] replica1_q [DEPTH];
  logic [DATA_W-1:0] replica1_d [DEPTH];
  logic [DATA_W-1:0] rd_data0;
  logic [DATA_W-1:0] rd_data1;

  // The first message supplies the upper address bits; no reset dependency.
  assign page_addr_A = {y0_in_A, y1_in_A};
  assign page_addr_B = {y0_in_B, y1_in_B};

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    replica0_d = replica0_q;
    replica1_d = replica1_q;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        replica0_d[i] = '0;
        replica1_d[i] = '0;
      end
    end else if (we) begin
      replica0_d[page_write_addr_replicate_0] = lut_in_bank0_replicate_0;
      replica1_d[page_write_addr_replicate_1] = lut_in_bank0_replicate_1;
    end
  end

  // NOTE: the storage is built from flops rather than a RAM macro because every entry must clear on reset.
  always_ff @(posedge write_clk) begin
    // NOTE: state updates use <= so all flops sample the pre-edge values together.
    replica0_q <= replica0_d;
    replica1_q <= replica1_d;
  end

  // Reads see only the registered array, so a same-address write appears after the edge.
  assign rd_data0 = replica0_q[page_addr_A];
  assign rd_data1 = replica1_q[page_addr_B];

`ifdef SYM_VN_RANK_RD_REG_EN
  logic [DATA_W-1:0] lut_data0_q, lut_data0_d;
  logic [DATA_W-1:0] lut_data1_q, lut_data1_d;

  always_comb begin
    lut_data0_d = rst ? '0 : rd_data0;
    lut_data1_d = rst ? '0 : rd_data1;
  end

  always_ff @(posedge write_clk) begin
    lut_data0_q <= lut_data0_d;
    lut_data1_q <= lut_data1_d;
  end

  assign lut_data0 = lut_data0_q;
  assign lut_data1 = lut_data1_q;
`else
  assign lut_data0 = rd_data0;
  assign lut_data1 = rd_data1;
`endif

endmodule

// File: tb/tb_sym_vn_rank_lut.sv
// Scoreboard bench for sym_vn_rank_lut; read latency follows SYM_VN_RANK_RD_REG_EN.
module tb_sym_vn_rank_lut;

`ifdef SYM_VN_RANK_RD_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       write_clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] y0_in_A = '0, y0_in_B = '0;
  logic [2:0] y1_in_A = '0, y1_in_B = '0;
  logic [4:0] page_addr_A, page_addr_B;
  logic [2:0] lut_data0, lut_data1;
  logic [2:0] wd0 = '0, wd1 = '0;
  logic [4:0] wa0 = '0, wa1 = '0;
  logic       we = 1'b0;

  logic rd_req = 1'b0;
  logic rd_req_q = 1'b0;

  typedef struct {logic [4:0] pa; logic [4:0] pb;} addr_exp_t;
  typedef struct {logic [2:0] d0; logic [2:0] d1;} data_exp_t;
  addr_exp_t addr_q[$];
  data_exp_t data_q[$];

  int n_checks = 0;
  int n_fail = 0;

  sym_vn_rank_lut dut (
    .write_clk                   (write_clk),
    .rst                         (rst),
    .y0_in_A                     (y0_in_A),
    .y1_in_A                     (y1_in_A),
    .y0_in_B                     (y0_in_B),
    .y1_in_B                     (y1_in_B),
    .page_addr_A                 (page_addr_A),
    .page_addr_B                 (page_addr_B),
    .lut_data0                   (lut_data0),
    .lut_data1                   (lut_data1),
    .lut_in_bank0_replicate_0    (wd0),
    .page_write_addr_replicate_0 (wa0),
    .lut_in_bank0_replicate_1    (wd1),
    .page_write_addr_replicate_1 (wa1),
    .we                          (we)
  );

  always #5 write_clk = ~write_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: address checks on the issue cycle, data checks LAT cycles later.
  always @(posedge write_clk) rd_req_q <= rd_req;

  always @(negedge write_clk) begin
    addr_exp_t ae;
    data_exp_t de;
    if (rd_req) begin
      if (addr_q.size() == 0) check("addr_q_underflow", 1, 0);
      else begin
        ae = addr_q.pop_front();
        check("page_addr_A", {27'd0, page_addr_A}, {27'd0, ae.pa});
        check("page_addr_B", {27'd0, page_addr_B}, {27'd0, ae.pb});
      end
    end
    if ((LAT == 0) ? rd_req : rd_req_q) begin
      if (data_q.size() == 0) check("data_q_underflow", 1, 0);
      else begin
        de = data_q.pop_front();
        check("lut_data0", {29'd0, lut_data0}, {29'd0, de.d0});
        check("lut_data1", {29'd0, lut_data1}, {29'd0, de.d1});
      end
    end
  end

  task automatic set_write(input logic en, input logic [4:0] a0, input logic [2:0] d0,
                           input logic [4:0] a1, input logic [2:0] d1);
    we = en; wa0 = a0; wd0 = d0; wa1 = a1; wd1 = d1;
  endtask

  task automatic wr(input logic en, input logic [4:0] a0, input logic [2:0] d0,
                    input logic [4:0] a1, input logic [2:0] d1);
    set_write(en, a0, d0, a1, d1);
    @(posedge write_clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] y0a, input logic [2:0] y1a,
                    input logic [1:0] y0b, input logic [2:0] y1b,
                    input logic [4:0] epa, input logic [4:0] epb,
                    input logic [2:0] e0, input logic [2:0] e1);
    y0_in_A = y0a; y1_in_A = y1a; y0_in_B = y0b; y1_in_B = y1b;
    addr_q.push_back('{pa: epa, pb: epb});
    data_q.push_back('{d0: e0, d1: e1});
    rd_req = 1'b1;
    @(posedge write_clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge write_clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a, b;
    @(posedge write_clk); #1;

    // Reset then sweep: everything reads 0, B walks the opposite direction.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      b = 5'(31 - i);
      rd(a[4:3], a[2:0], b[4:3], b[2:0], 5'(i), 5'(31 - i), 3'd0, 3'd0);
    end

    // Address composition vectors.
    rd(2'b10, 3'b011, 2'b11, 3'b111, 5'd19, 5'd31, 3'd0, 3'd0);
    rd(2'b01, 3'b000, 2'b00, 3'b001, 5'd8, 5'd1, 3'd0, 3'd0);

    // Independent writes at the same address, then read both ports.
    wr(1'b1, 5'd19, 3'd5, 5'd19, 3'd2);
    rd(2'b10, 3'b011, 2'b10, 3'b011, 5'd19, 5'd19, 3'd5, 3'd2);
    // Cross-read: A at 19, B at 3 (unwritten).
    rd(2'b10, 3'b011, 2'b00, 3'b011, 5'd19, 5'd3, 3'd5, 3'd0);

    // we=0 must not store.
    wr(1'b0, 5'd3, 3'd7, 5'd3, 3'd7);
    rd(2'b00, 3'b011, 2'b00, 3'b011, 5'd3, 5'd3, 3'd0, 3'd0);

    // Different addresses per replica in the same cycle.
    wr(1'b1, 5'd7, 3'd3, 5'd12, 3'd4);
    rd(2'b00, 3'b111, 2'b01, 3'b100, 5'd7, 5'd12, 3'd3, 3'd4);
    rd(2'b00, 3'b111, 2'b00, 3'b111, 5'd7, 5'd7, 3'd3, 3'd0);

    // Reset beats write; all entries clear.
    set_write(1'b1, 5'd7, 3'd6, 5'd7, 3'd6);
    do_reset();
    we = 1'b0;
    rd(2'b00, 3'b111, 2'b00, 3'b111, 5'd7, 5'd7, 3'd0, 3'd0);
    rd(2'b10, 3'b011, 2'b01, 3'b100, 5'd19, 5'd12, 3'd0, 3'd0);

    // Fill both replicas with addr[2:0] ^ 3'b101.
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      wr(1'b1, a, a[2:0] ^ 3'b101, a, a[2:0] ^ 3'b101);
    end

    // Read-during-write at addr 10: old value (010^101 = 7) now, new data afterwards.
    set_write(1'b1, 5'd10, 3'd1, 5'd10, 3'd2);
    rd(2'b01, 3'b010, 2'b01, 3'b010, 5'd10, 5'd10, 3'd7, 3'd7);
    we = 1'b0;
    rd(2'b01, 3'b010, 2'b01, 3'b010, 5'd10, 5'd10, 3'd1, 3'd2);

    // Random address pairs against the fill pattern (addr 10 excluded).
    for (int i = 0; i < 24; i++) begin
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      if (a == 5'd10) a = 5'd11;
      if (b == 5'd10) b = 5'd9;
      rd(a[4:3], a[2:0], b[4:3], b[2:0], a, b, a[2:0] ^ 3'b101, b[2:0] ^ 3'b101);
    end

    for (int k = 0; k < 10 && (data_q.size() != 0 || addr_q.size() != 0); k++)
      @(posedge write_clk);
    @(negedge write_clk); #1;
    check("data_q_drained", data_q.size(), 0);
    check("addr_q_drained", addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
